// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: synchronised SCLK/CS/MOSI, byte shift in/out with a one-byte TX holding buffer.
// Define SPI_PERIPHERAL_ECHO_EN to transmit the last received byte when the holding buffer is empty.
`timescale 1ns/1ps
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_now;
  logic                   cs_n_now;
  logic                   mosi_now;
  logic                   sclk_rise;
  logic                   sclk_fall;

  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] rx_data;
  logic [7:0] buf_data;
  logic [7:0] load_val;
  logic [7:0] fill_val;
  logic [2:0] bit_cnt;
  logic       reload_pending;
  logic       tx_ready;
  logic       consume;
  logic       rx_valid;
  logic       frame_err;

  assign sclk_now  = sclk_sync[SYNC_STAGES-1];
  assign cs_n_now  = cs_sync[SYNC_STAGES-1];
  assign mosi_now  = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_now & ~sclk_prev;
  assign sclk_fall = ~sclk_now & sclk_prev;

`ifdef SPI_PERIPHERAL_ECHO_EN
  assign fill_val = rx_data;
`else
  assign fill_val = 8'h00;
`endif

  // Outputs decode directly from registered state.
  assign o_miso      = (state == SHIFT) ? tx_shift[7] : 1'b0;
  assign o_miso_oe   = (state != IDLE);
  assign o_busy      = (state != IDLE);
  assign o_tx_ready  = tx_ready;
  assign o_rx_data   = rx_data;
  assign o_rx_valid  = rx_valid;
  assign o_frame_err = frame_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= {SYNC_STAGES{1'b0}};
      cs_sync   <= {SYNC_STAGES{1'b1}};
      mosi_sync <= {SYNC_STAGES{1'b0}};
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_prev <= sclk_now;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    load_val   = tx_ready ? fill_val : buf_data;
    if (cs_n_now) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = LOAD;
        LOAD:    state_next = SHIFT;
        SHIFT:   state_next = SHIFT;
        default: state_next = IDLE;
      endcase
      // A consume is the LOAD cycle or the first falling edge after a completed byte.
      consume = (state == LOAD) || ((state == SHIFT) && sclk_fall && reload_pending);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_shift       <= 8'h00;
      rx_shift       <= 8'h00;
      rx_data        <= 8'h00;
      bit_cnt        <= 3'd0;
      reload_pending <= 1'b0;
      rx_valid       <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (cs_n_now) begin
        frame_err      <= (state != IDLE) && (bit_cnt != 3'd0);
        bit_cnt        <= 3'd0;
        rx_shift       <= 8'h00;
        reload_pending <= 1'b0;
      end else if (state == LOAD) begin
        tx_shift <= load_val;
      end else if (state == SHIFT) begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_now};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data        <= {rx_shift[6:0], mosi_now};
            rx_valid       <= 1'b1;
            reload_pending <= 1'b1;
          end
        end
        if (sclk_fall) begin
          if (reload_pending) begin
            tx_shift       <= load_val;
            reload_pending <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  // Consume reads the old buffer before a same-cycle write refills it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_data <= 8'h00;
      tx_ready <= 1'b1;
    end else if (i_tx_valid && tx_ready) begin
      buf_data <= i_tx_data;
      tx_ready <= 1'b0;
    end else if (consume) begin
      tx_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: vector table, corner sequences and randomized frames vs. a byte-level model.
`timescale 1ns/1ps
module tb_spi_peripheral;

`ifdef SPI_PERIPHERAL_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, frame_err, busy;
  logic [7:0] tx_data, rx_data;

  int tests = 0;
  int fails = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;

  // byte-level reference model of the holding buffer and last received byte
  bit         m_full;
  logic [7:0] m_buf;
  logic [7:0] m_last_rx;

  logic [7:0] fm [4];
  int         fw [4];
  logic [7:0] fd [4];
  logic [7:0] fgot [4];

  typedef struct {
    bit         wr;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vec [6];

  always #5 clk = ~clk;

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_frame_err(frame_err), .o_busy(busy)
  );

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic m_consume(output logic [7:0] v);
    v = m_full ? m_buf : (ECHO ? m_last_rx : 8'h00);
    m_full = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_before_write", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_write", tx_ready, 0);
    m_full = 1'b1;
    m_buf  = d;
  endtask

  task automatic tx_write_ignored(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_stays_low", tx_ready, 0);
  endtask

  task automatic spi_byte(input logic [7:0] mo, input int wr, input logic [7:0] wd,
                          output logic [7:0] mi);
    for (int b = 7; b >= 0; b--) begin
      mosi = mo[b];
      wait_clk(3);
      mi[b] = miso;
      wait_clk(1);
      sclk = 1'b1;
      wait_clk(4);
      if (b == 7 && wr == 1) tx_write(wd);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int n);
    int r0, f0;
    logic [7:0] e, got, dummy;
    r0 = rxv_cnt;
    f0 = ferr_cnt;
    cs_n = 1'b0;
    wait_clk(8);
    check("busy_oe_selected", {busy, miso_oe}, 2'b11);
    for (int i = 0; i < n; i++) begin
      m_consume(e);
      spi_byte(fm[i], fw[i], fd[i], got);
      m_last_rx = fm[i];
      fgot[i] = got;
      check("miso_byte", got, e);
      check("rx_data", rx_data, fm[i]);
    end
    m_consume(dummy);
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(8);
    check("rx_valid_cycles", rxv_cnt - r0, n);
    check("no_frame_err", ferr_cnt - f0, 0);
    check("idle_outputs", {busy, miso_oe, miso}, 3'b000);
  endtask

  task automatic abort_frame(input int rises);
    int r0, f0;
    logic [7:0] dummy;
    r0 = rxv_cnt;
    f0 = ferr_cnt;
    cs_n = 1'b0;
    wait_clk(8);
    m_consume(dummy);
    for (int k = 0; k < rises; k++) begin
      mosi = 1'($urandom_range(0, 1));
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      if (k < rises - 1) sclk = 1'b0;
    end
    cs_n = 1'b1;
    wait_clk(8);
    sclk = 1'b0;
    wait_clk(8);
    check("abort_frame_err", ferr_cnt - f0, 1);
    check("abort_no_rx_valid", rxv_cnt - r0, 0);
    check("abort_rx_data_kept", rx_data, m_last_rx);
    check("abort_idle", busy, 0);
  endtask

  initial begin
    int r0, f0, nb;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    m_full = 1'b0; m_buf = 8'h00; m_last_rx = 8'h00;
    wait_clk(4);
    check("reset_outputs", {miso, miso_oe, rx_valid, frame_err, busy, tx_ready}, 6'b000001);
    check("reset_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    wait_clk(4);

    // single-byte frames; entries 4 and 5 run with an empty buffer
    vec[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vec[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vec[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vec[3] = '{1'b1, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vec[4] = '{1'b0, 8'h00, 8'hC3, (ECHO ? 8'h5A : 8'h00), 8'hC3};
    vec[5] = '{1'b0, 8'h00, 8'h66, (ECHO ? 8'hC3 : 8'h00), 8'h66};
    for (int v = 0; v < 6; v++) begin
      if (vec[v].wr) tx_write(vec[v].tx);
      fm[0] = vec[v].mo; fw[0] = 0; fd[0] = 8'h00;
      run_frame(1);
      check("vec_miso", fgot[0], vec[v].exp_miso);
      check("vec_rx", rx_data, vec[v].exp_rx);
    end

    // write attempts while full are dropped; back-to-back 3-byte frame with refills
    tx_write(8'hA5);
    tx_write_ignored(8'hEE);
    fm[0] = 8'h12; fw[0] = 1; fd[0] = 8'h11;
    fm[1] = 8'h34; fw[1] = 1; fd[1] = 8'h22;
    fm[2] = 8'h56; fw[2] = 0; fd[2] = 8'h00;
    run_frame(3);
    check("b2b_byte0", fgot[0], 8'hA5);
    check("b2b_byte1", fgot[1], 8'h11);
    check("b2b_byte2", fgot[2], 8'h22);

    abort_frame(3);

    // reset in the middle of a byte
    tx_write(8'h77);
    r0 = rxv_cnt;
    f0 = ferr_cnt;
    cs_n = 1'b0;
    wait_clk(8);
    for (int k = 0; k < 4; k++) begin
      mosi = 1'b1;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    rst = 1'b1;
    wait_clk(2);
    check("midrst_outputs", {miso, miso_oe, rx_valid, frame_err, busy, tx_ready}, 6'b000001);
    check("midrst_rx_data", rx_data, 8'h00);
    cs_n = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    check("midrst_no_pulses", (rxv_cnt - r0) + (ferr_cnt - f0), 0);
    m_full = 1'b0; m_buf = 8'h00; m_last_rx = 8'h00;
    tx_write(8'hC6);
    fm[0] = 8'h9D; fw[0] = 0; fd[0] = 8'h00;
    run_frame(1);
    check("post_rst_miso", fgot[0], 8'hC6);

    // randomized frames checked against the model
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      if (m_full && $urandom_range(0, 2) == 0) tx_write_ignored(8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        abort_frame(int'($urandom_range(1, 7)));
      end else begin
        nb = int'($urandom_range(1, 3));
        for (int i = 0; i < nb; i++) begin
          fm[i] = 8'($urandom);
          fw[i] = int'($urandom_range(0, 1));
          fd[i] = 8'($urandom);
        end
        run_frame(nb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
